// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot loader.
// The master side feeds bytes and watches the writes; the loader is the slave.
interface inst_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (output rx_data, output rx_valid,
                    input  wr_en, input wr_addr, input wr_data);
    modport slave  (input  rx_data, input rx_valid,
                    output wr_en, output wr_addr, output wr_data);
endinterface

// File: rtl/inst_loader.sv
// Boot loader: unpacks a framed UART byte stream into instruction-RAM word writes
// and releases the CPU from reset once the image checksum matches.
//
// state  | meaning
// IDLE   | waiting for header 0xA5, other bytes ignored
// CNT_HI | expecting word count high byte
// CNT_LO | expecting word count low byte, range-checked here
// DATA   | packing bytes into words, one RAM write per 4th byte
// CSUM   | expecting checksum byte
// RUN    | image good, CPU released; only reset leaves
// ERR    | frame failed; a new 0xA5 restarts the frame
module inst_loader #(
    parameter int DEPTH_LOG2 = 7,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    inst_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_VAL = TW'(TIMEOUT);
    localparam logic [7:0] HDR = 8'hA5;

    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CSUM, RUN, ERR} state_t;

    state_t                state, state_nx;
    logic [TW-1:0]         tcnt;
    logic [7:0]            cnt_hi;
    logic [DEPTH_LOG2:0]   n_words;
    logic [DEPTH_LOG2:0]   word_idx;
    logic [1:0]            byte_idx;
    logic [23:0]           word_sh;
    logic [7:0]            csum;
    logic [15:0]           n_full;
    logic                  active, tmo, accept, bad_n, last_word;
    logic                  hold_d, done_d, error_d;

    assign active    = (state == CNT_HI) || (state == CNT_LO) || (state == DATA) || (state == CSUM);
    assign tmo       = active && (tcnt == TMO_VAL);
    assign accept    = bus.rx_valid && !tmo;
    assign n_full    = {cnt_hi, bus.rx_data};
    assign bad_n     = (n_full == 16'd0) || ({1'b0, n_full} > 17'(1 << DEPTH_LOG2));
    assign last_word = (word_idx == n_words - (DEPTH_LOG2+1)'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.rx_valid && bus.rx_data == HDR) state_nx = CNT_HI;
            CNT_HI:  if (tmo) state_nx = ERR;
                     else if (bus.rx_valid) state_nx = CNT_LO;
            CNT_LO:  if (tmo) state_nx = ERR;
                     else if (bus.rx_valid) state_nx = bad_n ? ERR : DATA;
            DATA:    if (tmo) state_nx = ERR;
                     else if (bus.rx_valid && byte_idx == 2'd3 && last_word) state_nx = CSUM;
            CSUM:    if (tmo) state_nx = ERR;
                     else if (bus.rx_valid) state_nx = (bus.rx_data == csum) ? RUN : ERR;
            RUN:     state_nx = RUN;
            ERR:     if (bus.rx_valid && bus.rx_data == HDR) state_nx = CNT_HI;
            default: state_nx = IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they come straight off flops.
    always_comb begin
        hold_d  = (state_nx != RUN);
        done_d  = (state_nx == RUN);
        error_d = (state_nx == ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            cpu_hold <= hold_d;
            done     <= done_d;
            error    <= error_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  tcnt <= '0;
        else if (!active || tmo)     tcnt <= '0;
        else if (bus.rx_valid)       tcnt <= '0;
        else                         tcnt <= tcnt + TW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_hi      <= '0;
            n_words     <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            word_sh     <= '0;
            csum        <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            if ((state == IDLE || state == ERR) && bus.rx_valid && bus.rx_data == HDR)
                csum <= '0;
            else if (accept) begin
                case (state)
                    CNT_HI: begin
                        cnt_hi <= bus.rx_data;
                        csum   <= csum ^ bus.rx_data;
                    end
                    CNT_LO: begin
                        n_words  <= n_full[DEPTH_LOG2:0];
                        csum     <= csum ^ bus.rx_data;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                    DATA: begin
                        word_sh  <= {word_sh[15:0], bus.rx_data};
                        csum     <= csum ^ bus.rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_data <= {word_sh, bus.rx_data};
                            bus.wr_addr <= 32'(word_idx) << 2;
                            word_idx    <= word_idx + (DEPTH_LOG2+1)'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected RAM writes are queued when a frame
// is built and retired by a monitor as wr_en pulses appear.
`timescale 1ns/1ps
module tb_inst_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cpu_hold, done, error;

    inst_loader_if bus ();

    inst_loader #(.DEPTH_LOG2(7), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    logic [31:0] last_addr = '0;
    logic [63:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] wq[$];

    always @(negedge clk) begin
        if (reset && bus.wr_en) begin
            wr_count++;
            last_addr = bus.wr_addr;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h expected none", bus.wr_addr, bus.wr_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_data} !== e) begin
                    failures++;
                    $display("FAIL write got=%h/%h expected=%h/%h", bus.wr_addr, bus.wr_data, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic send_tx(input int gap);
        @(negedge clk);
        while (tx_q.size() > 0) begin
            bus.rx_data  = tx_q.pop_front();
            bus.rx_valid = 1'b1;
            @(negedge clk);
            bus.rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    // Frame from wq; checksum is computed here unless a bad one is forced.
    task automatic build_frame(input bit bad, input logic [7:0] bad_val);
        logic [7:0] cs;
        logic [15:0] n;
        n = 16'(wq.size());
        cs = n[15:8] ^ n[7:0];
        tx_q.push_back(8'hA5);
        tx_q.push_back(n[15:8]);
        tx_q.push_back(n[7:0]);
        for (int i = 0; i < wq.size(); i++) begin
            logic [31:0] w;
            w = wq[i];
            for (int b = 3; b >= 0; b--) begin
                tx_q.push_back(w[b*8 +: 8]);
                cs = cs ^ w[b*8 +: 8];
            end
            exp_q.push_back({32'(i * 4), w});
        end
        tx_q.push_back(bad ? bad_val : cs);
    endtask

    task automatic nominal_words();
        wq.delete();
        wq.push_back(32'h08000003);
        wq.push_back(32'h201C0000);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        wr_count = 0;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_writes_pending got=%0d expected=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_status(input string name, input logic eh, input logic ed, input logic ee);
        checks += 3;
        if (cpu_hold !== eh) begin failures++; $display("FAIL %s_cpu_hold got=%b expected=%b", name, cpu_hold, eh); end
        if (done !== ed)     begin failures++; $display("FAIL %s_done got=%b expected=%b", name, done, ed); end
        if (error !== ee)    begin failures++; $display("FAIL %s_error got=%b expected=%b", name, error, ee); end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 3;
        if (bus.wr_en !== 1'b0)    begin failures++; $display("FAIL reset_wr_en got=%b expected=0", bus.wr_en); end
        if (bus.wr_addr !== 32'h0) begin failures++; $display("FAIL reset_wr_addr got=%h expected=0", bus.wr_addr); end
        if (bus.wr_data !== 32'h0) begin failures++; $display("FAIL reset_wr_data got=%h expected=0", bus.wr_data); end
        check_status("reset", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_nominal();
        do_reset();
        nominal_words();
        build_frame(1'b0, 8'h00);
        send_tx(2);
        drain("nominal");
        check_status("nominal", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_bad_csum();
        do_reset();
        nominal_words();
        build_frame(1'b1, 8'h1F);
        send_tx(1);
        drain("badcs");
        checks++;
        if (wr_count != 2) begin failures++; $display("FAIL badcs_write_count got=%0d expected=2", wr_count); end
        check_status("badcs", 1'b1, 1'b0, 1'b1);
        build_frame(1'b0, 8'h00);
        send_tx(1);
        drain("badcs_retry");
        check_status("badcs_retry", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_count_limits();
        do_reset();
        tx_q.push_back(8'hA5); tx_q.push_back(8'h00); tx_q.push_back(8'h81);
        send_tx(0);
        repeat (2) @(negedge clk);
        check_status("cnt129", 1'b1, 1'b0, 1'b1);
        tx_q.push_back(8'hA5); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
        send_tx(0);
        repeat (2) @(negedge clk);
        check_status("cnt0", 1'b1, 1'b0, 1'b1);
        checks++;
        if (wr_count != 0) begin failures++; $display("FAIL cnt_bad_writes got=%0d expected=0", wr_count); end
        wq.delete();
        for (int i = 0; i < 128; i++) wq.push_back($urandom());
        build_frame(1'b0, 8'h00);
        send_tx(0);
        drain("cnt128");
        checks += 2;
        if (last_addr !== 32'h1FC) begin failures++; $display("FAIL cnt128_last_addr got=%h expected=1fc", last_addr); end
        if (wr_count != 128) begin failures++; $display("FAIL cnt128_write_count got=%0d expected=128", wr_count); end
        check_status("cnt128", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        do_reset();
        tx_q.push_back(8'hA5); tx_q.push_back(8'h00); tx_q.push_back(8'h01); tx_q.push_back(8'h0A);
        send_tx(0);
        repeat (50) @(negedge clk);
        check_status("tmo_early", 1'b1, 1'b0, 1'b0);
        repeat (60) @(negedge clk);
        check_status("tmo", 1'b1, 1'b0, 1'b1);
        checks++;
        if (wr_count != 0) begin failures++; $display("FAIL tmo_writes got=%0d expected=0", wr_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tx_q.push_back(8'h00); tx_q.push_back(8'hFF);
        nominal_words();
        build_frame(1'b0, 8'h00);
        send_tx(0);
        drain("b2b");
        check_status("b2b", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_q.push_back(8'hA5); tx_q.push_back(8'h00); tx_q.push_back(8'h02);
        tx_q.push_back(8'h08); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
        tx_q.push_back(8'h03); tx_q.push_back(8'h20);
        exp_q.push_back({32'h0, 32'h08000003});
        send_tx(1);
        drain("mid_pre");
        #2 reset = 1'b0;
        #1;
        checks += 2;
        if (bus.wr_data !== 32'h0) begin failures++; $display("FAIL mid_rst_wr_data got=%h expected=0", bus.wr_data); end
        if (bus.wr_en !== 1'b0)    begin failures++; $display("FAIL mid_rst_wr_en got=%b expected=0", bus.wr_en); end
        check_status("mid_rst", 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        nominal_words();
        build_frame(1'b0, 8'h00);
        send_tx(1);
        drain("mid_reload");
        check_status("mid_reload", 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        test_reset();
        test_nominal();
        test_bad_csum();
        test_count_limits();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
